muxnm_rr_pipe: RTL and testbench
================================

// Module: muxnm_rr_pipe
// PURPOSE
//  N-channel, DATA_WIDTH-wide selector with per-channel valid/ready handshake.
//  Round-robin grant replaces the external select; a registered output stage
//  carries the winning beat. Merges several producer streams (e.g. request
//  queues) onto one consumer port without an external select controller.
// PARAMETERS
//  NUM_INPUTS  4  number of input channels, >=1, need not be a power of two
//  DATA_WIDTH  8  bits per channel beat
//  SEL_WIDTH   (localparam) max(1,$clog2(NUM_INPUTS)), width of out_sel
// PORTS
//  clk       in   1                      rising-edge clock
//  rst       in   1                      asynchronous, active-high reset
//  in_valid  in   NUM_INPUTS             per-channel beat valid
//  in_data   in   NUM_INPUTS*DATA_WIDTH  channel j at in_data[j*DATA_WIDTH +: DATA_WIDTH]
//  in_ready  out  NUM_INPUTS             per-channel accept, one-hot or zero
//  out_valid out  1                      output register holds a beat
//  out_data  out  DATA_WIDTH             registered beat
//  out_sel   out  SEL_WIDTH              index of channel that supplied out_data
//  out_ready in   1                      consumer accepts when high with out_valid
//  in_last   in   NUM_INPUTS             [MUXNM_RR_PIPE_LOCK_EN only] end-of-packet
//  out_last  out  1                      [MUXNM_RR_PIPE_LOCK_EN only] registered in_last
// BEHAVIOUR
//  - Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, ptr=0,
//    locked=0, out_last=0. in_ready is all-zero while rst is high.
//  - Mid-transfer reset drops the held beat. No beat is accepted in a reset cycle.
//  - load = (!out_valid | out_ready) & |in_valid.
//  - Grant g: first index with in_valid set, scanning ptr, ptr+1, ...
//    NUM_INPUTS-1, 0, ... (modulo wrap).
//  - in_ready[g] = load; all other in_ready bits are 0. in_ready is
//    combinational from in_valid/out_valid/out_ready. Producers must not make
//    in_valid depend on in_ready.
//  - On a load edge: out_data<=in_data[g], out_sel<=g, out_valid<=1,
//    ptr<=(g==NUM_INPUTS-1)?0:g+1.
//  - out_ready & out_valid & !load: out_valid<=0 (data/sel hold).
//  - No load and !out_ready: all outputs hold (backpressure). out_data is
//    stable while out_valid & !out_ready.
//  - Latency 1 cycle from input acceptance to out_valid. Sustained throughput
//    is 1 beat/cycle when out_ready=1 (simultaneous drain and load).
//  - Fairness: with all channels continuously valid, grants cycle 0,1,..,N-1,0.
//    No channel waits more than NUM_INPUTS-1 grants.
//  - NUM_INPUTS=1: g=0 always, ptr stays 0, out_sel=0.
//  - in_valid withdrawn before acceptance is legal. The scan uses current
//    valid bits only, with no stored request.
// CONFIGURATION
//  MUXNM_RR_PIPE_LOCK_EN defined:
//   - in_last/out_last ports exist.
//   - Accepted beat with in_last[g]=0: locked<=1, lock_ch<=g, ptr unchanged.
//   - While locked, grant is forced to lock_ch. Other channels see in_ready=0
//     even if valid. in_ready[lock_ch]=(!out_valid|out_ready)&in_valid[lock_ch].
//   - Accepted beat with in_last=1: locked<=0, ptr<=lock_ch+1 (wrap).
//     out_last<=in_last[g] on every load.
//  MUXNM_RR_PIPE_LOCK_EN not defined: ports absent, each beat arbitrates
//   independently.
// TESTING
//  1 N=4,W=8: assert rst mid-cycle with out_valid=1 -> out_valid, out_data,
//    out_sel drop to 0 before the next clk edge.
//  2 All in_valid=1, data j=8'hA0+j, out_ready=1 -> out_sel 0,1,2,3,0 on
//    consecutive cycles, out_data A0,A1,A2,A3,A0, no bubbles.
//  3 Only ch2 valid (8'h5C), out_ready=0 for 3 cycles -> out_valid=1, data 5C
//    held, in_ready=0 after first load. Raising out_ready gives one transfer
//    and reloads the same cycle.
//  4 ptr=3, valid={ch1,ch0} -> grant ch0 (wrap), then ch1. in_ready is one-hot
//    every cycle (assertion).
//  5 N=3 (non-power-of-two), all valid -> out_sel 0,1,2,0. SEL_WIDTH=2,
//    out_sel never 3.
//  6 LOCK_EN: ch1 sends 3 beats (last on 3rd), ch0 and ch2 valid throughout ->
//    out_sel 1,1,1,2,0. out_last=1 only on 3rd beat.

Source files
------------

// File: rtl/muxnm_rr_pipe.sv
// ---------------------------------------------------------------------------
// muxnm_rr_pipe
//
// Purpose
//   Merges NUM_INPUTS producer streams onto one consumer port. A round-robin
//   arbiter picks the winning channel; the winning beat is captured in a
//   single output register. The arbiter can drain and reload that register in
//   the same cycle, so throughput is one beat per cycle. A grant is chosen
//   only from the in_valid bits of the current cycle. No request is stored.
//
// Optional feature (macro MUXNM_RR_PIPE_LOCK_EN)
//   When defined, in_last/out_last ports are present. A channel that delivers
//   a beat with in_last=0 keeps the grant until it delivers a beat with
//   in_last=1. After that beat the pointer moves past the locking channel.
//
// Parameters
//   NUM_INPUTS  number of channels (>=1, any value, not only powers of two)
//   DATA_WIDTH  bits per beat
//   SEL_WIDTH   derived, max(1, clog2(NUM_INPUTS))
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   per-channel beat valid
//   in_data    channel j at in_data[j*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   per-channel accept (one-hot or zero, combinational)
//   out_valid  output register holds a beat
//   out_data   registered beat
//   out_sel    channel index that supplied out_data
//   out_ready  consumer accept
//   in_last    (lock build only) end-of-packet marker per channel
//   out_last   (lock build only) registered in_last of the winning beat
// ---------------------------------------------------------------------------
module muxnm_rr_pipe #(
    parameter int  NUM_INPUTS = 4,
    parameter int  DATA_WIDTH = 8,
    localparam int SEL_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_sel,
    input  logic                             out_ready
`ifdef MUXNM_RR_PIPE_LOCK_EN
    ,
    input  logic [NUM_INPUTS-1:0]            in_last,
    output logic                             out_last
`endif
);

    // Returns the pointer value after channel g. Wraps from the last channel to 0.
    function automatic logic [SEL_WIDTH-1:0] next_ptr(input logic [SEL_WIDTH-1:0] g);
        logic [SEL_WIDTH-1:0] r;
        if (g == SEL_WIDTH'(NUM_INPUTS - 1)) begin
            r = '0;
        end else begin
            r = g + SEL_WIDTH'(1'b1);
        end
        return r;
    endfunction

    logic [SEL_WIDTH-1:0]  ptr_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [SEL_WIDTH-1:0]  out_sel_r;

    logic [NUM_INPUTS-1:0] req_s;
    logic [SEL_WIDTH-1:0]  grant_s;
    logic [DATA_WIDTH-1:0] grant_data_s;
    logic                  space_s;
    logic                  load_s;
    logic [NUM_INPUTS-1:0] in_ready_s;

`ifdef MUXNM_RR_PIPE_LOCK_EN
    logic                  locked_r;
    logic [SEL_WIDTH-1:0]  lock_ch_r;
    logic                  out_last_r;
    logic                  grant_last_s;

    // While locked, only the locking channel can request, so the scan below
    // always lands on it.
    always_comb begin
        req_s = '0;
        if (locked_r) begin
            req_s[lock_ch_r] = in_valid[lock_ch_r];
        end else begin
            req_s = in_valid;
        end
    end

    // in_last of the winning channel.
    always_comb begin
        grant_last_s = in_last[grant_s];
    end
`else
    // Without locking, every valid channel takes part in each arbitration.
    always_comb begin
        req_s = in_valid;
    end
`endif

    // Round-robin scan: the first requesting index at or after ptr, modulo NUM_INPUTS.
    always_comb begin
        logic [SEL_WIDTH:0]   sum_v;
        logic [SEL_WIDTH-1:0] idx_v;
        logic                 found_v;
        sum_v   = '0;
        idx_v   = '0;
        found_v = 1'b0;
        grant_s = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            sum_v = {1'b0, ptr_r} + (SEL_WIDTH+1)'(k);
            if (sum_v >= (SEL_WIDTH+1)'(NUM_INPUTS)) begin
                sum_v = sum_v - (SEL_WIDTH+1)'(NUM_INPUTS);
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[SEL_WIDTH-1:0];
            if (!found_v && req_s[idx_v]) begin
                found_v = 1'b1;
                grant_s = idx_v;
            end else begin
                found_v = found_v;
            end
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        grant_data_s = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (grant_s == SEL_WIDTH'(j)) begin
                grant_data_s = in_data[j*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    // A load happens when the register is empty or being drained and a
    // channel requests. While reset is high, no beat is accepted.
    always_comb begin
        space_s = !out_valid_r || out_ready;
        load_s  = !rst && space_s && (|req_s);
    end

    // Only the granted channel sees ready, and only on a load.
    always_comb begin
        in_ready_s = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (load_s && (grant_s == SEL_WIDTH'(j))) begin
                in_ready_s[j] = 1'b1;
            end else begin
                in_ready_s[j] = 1'b0;
            end
        end
    end

    // Output register, arbitration pointer and (optionally) lock state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
            ptr_r       <= '0;
`ifdef MUXNM_RR_PIPE_LOCK_EN
            locked_r    <= 1'b0;
            lock_ch_r   <= '0;
            out_last_r  <= 1'b0;
`endif
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_sel_r   <= grant_s;
`ifdef MUXNM_RR_PIPE_LOCK_EN
            out_last_r  <= grant_last_s;
            if (!grant_last_s) begin
                // Mid-packet: hold the grant and leave the pointer unchanged.
                locked_r  <= 1'b1;
                lock_ch_r <= grant_s;
            end else begin
                // grant_s equals lock_ch_r whenever a packet was in progress.
                locked_r  <= 1'b0;
                ptr_r     <= next_ptr(grant_s);
            end
`else
            ptr_r       <= next_ptr(grant_s);
`endif
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
`ifdef MUXNM_RR_PIPE_LOCK_EN
    assign out_last  = out_last_r;
`endif

endmodule

// File: tb/tb_muxnm_rr_pipe.sv
// ---------------------------------------------------------------------------
// tb_muxnm_rr_pipe
//   Directed self-checking bench for muxnm_rr_pipe. It uses a 4-channel
//   instance and a 3-channel instance. Both share the clock and reset.
//   Inputs change 1 ns after a rising edge. Outputs are sampled at least 1 ns
//   after that change.
// ---------------------------------------------------------------------------
module tb_muxnm_rr_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  in_valid4;
    logic [31:0] in_data4;
    logic [3:0]  in_ready4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [1:0]  out_sel4;
    logic        out_ready4;

    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_ready3;

`ifdef MUXNM_RR_PIPE_LOCK_EN
    logic [3:0]  in_last4;
    logic        out_last4;
    logic [2:0]  in_last3;
    logic        out_last3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muxnm_rr_pipe #(.NUM_INPUTS(4), .DATA_WIDTH(8)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_sel(out_sel4),
        .out_ready(out_ready4)
`ifdef MUXNM_RR_PIPE_LOCK_EN
        , .in_last(in_last4), .out_last(out_last4)
`endif
    );

    muxnm_rr_pipe #(.NUM_INPUTS(3), .DATA_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
        .out_ready(out_ready3)
`ifdef MUXNM_RR_PIPE_LOCK_EN
        , .in_last(in_last3), .out_last(out_last3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid4  = 4'h0;
        in_data4   = 32'h0;
        out_ready4 = 1'b0;
        in_valid3  = 3'h0;
        in_data3   = 24'h0;
        out_ready3 = 1'b0;
`ifdef MUXNM_RR_PIPE_LOCK_EN
        in_last4   = 4'hF;
        in_last3   = 3'h7;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Reset state at time zero, and in_ready gating while rst is high.
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        in_valid4  = 4'hF;
        out_ready4 = 1'b1;
        #2;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid4); end
        total++; if (out_data4 !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data4); end
        total++; if (out_sel4 !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", out_sel4); end
        total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", in_ready4); end
        tick();
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_noload: got %b want 0", out_valid4); end
        do_reset();
    endtask

    // Reset asserted mid-cycle while a beat is held clears the outputs at once.
    task automatic test_async_reset();
        do_reset();
        in_valid4 = 4'b0100;
        in_data4  = {8'h00, 8'h5C, 8'h00, 8'h00};
        tick();
        total++; if (out_valid4 !== 1'b1 || out_data4 !== 8'h5C) begin bad++; $display("FAIL arst_preload: got v=%b d=%h want v=1 d=5c", out_valid4, out_data4); end
        in_valid4 = 4'hF;
        #3;
        rst = 1'b1;
        #1;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", out_valid4); end
        total++; if (out_data4 !== 8'h00) begin bad++; $display("FAIL arst_data: got %h want 00", out_data4); end
        total++; if (out_sel4 !== 2'd0) begin bad++; $display("FAIL arst_sel: got %0d want 0", out_sel4); end
        total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL arst_ready: got %b want 0000", in_ready4); end
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
    endtask

    // All channels valid with the consumer always ready: grants rotate with no bubbles.
    task automatic test_round_robin();
        logic [1:0] exp_sel;
        logic [3:0] exp_rdy;
        do_reset();
        in_valid4  = 4'hF;
        in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready4 = 1'b1;
        #1;
        total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL rr_first_ready: got %b want 0001", in_ready4); end
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_sel = 2'(i % 4);
            exp_rdy = 4'b0001 << ((i + 1) % 4);
            total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b want 1", i, out_valid4); end
            total++; if (out_sel4 !== exp_sel) begin bad++; $display("FAIL rr_sel[%0d]: got %0d want %0d", i, out_sel4, exp_sel); end
            total++; if (out_data4 !== (8'hA0 + 8'(exp_sel))) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, out_data4, 8'hA0 + 8'(exp_sel)); end
            total++; if (in_ready4 !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready4, exp_rdy); end
        end
        clear_inputs();
        tick();
    endtask

    // A single channel under backpressure: the beat is held, then drained and reloaded in the same cycle.
    task automatic test_backpressure();
        do_reset();
        in_valid4  = 4'b0100;
        in_data4   = {8'h00, 8'h5C, 8'h00, 8'h00};
        out_ready4 = 1'b0;
        #1;
        total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL bp_first_ready: got %b want 0100", in_ready4); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid4 !== 1'b1 || out_data4 !== 8'h5C || out_sel4 !== 2'd2) begin bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want v=1 d=5c s=2", i, out_valid4, out_data4, out_sel4); end
            total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", i, in_ready4); end
        end
        out_ready4 = 1'b1;
        #1;
        total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL bp_reload_ready: got %b want 0100", in_ready4); end
        tick();
        total++; if (out_valid4 !== 1'b1 || out_data4 !== 8'h5C) begin bad++; $display("FAIL bp_reload: got v=%b d=%h want v=1 d=5c", out_valid4, out_data4); end
        in_valid4 = 4'b0000;
        tick();
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid4); end
        total++; if (out_data4 !== 8'h5C) begin bad++; $display("FAIL bp_drain_data_hold: got %h want 5c", out_data4); end
    endtask

    // Continues from test_backpressure with ptr at 3: the scan wraps to ch0, then goes to ch1.
    task automatic test_wrap();
        in_valid4  = 4'b0011;
        in_data4   = {8'h00, 8'h00, 8'h22, 8'h11};
        out_ready4 = 1'b1;
        #1;
        total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL wrap_ready0: got %b want 0001", in_ready4); end
        tick();
        total++; if (out_sel4 !== 2'd0 || out_data4 !== 8'h11) begin bad++; $display("FAIL wrap_beat0: got s=%0d d=%h want s=0 d=11", out_sel4, out_data4); end
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL wrap_ready1: got %b want 0010", in_ready4); end
        tick();
        total++; if (out_sel4 !== 2'd1 || out_data4 !== 8'h22) begin bad++; $display("FAIL wrap_beat1: got s=%0d d=%h want s=1 d=22", out_sel4, out_data4); end
        total++; if ($countones(in_ready4) > 1) begin bad++; $display("FAIL wrap_onehot: got %b want at most one bit", in_ready4); end
        // A valid withdrawn before acceptance leaves nothing behind.
        in_valid4 = 4'b0000;
        tick();
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL wrap_withdraw: got %b want 0", out_valid4); end
    endtask

    // Three channels (not a power of two): grants wrap 0,1,2,0 and never reach index 3.
    task automatic test_n3();
        logic [1:0] exp_sel;
        do_reset();
        in_valid3  = 3'b111;
        in_data3   = {8'h32, 8'h31, 8'h30};
        out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_sel = 2'(i % 3);
            total++; if (out_valid3 !== 1'b1 || out_sel3 !== exp_sel) begin bad++; $display("FAIL n3_sel[%0d]: got v=%b s=%0d want v=1 s=%0d", i, out_valid3, out_sel3, exp_sel); end
            total++; if (out_data3 !== (8'h30 + 8'(exp_sel))) begin bad++; $display("FAIL n3_data[%0d]: got %h want %h", i, out_data3, 8'h30 + 8'(exp_sel)); end
        end
        clear_inputs();
        tick();
    endtask

`ifdef MUXNM_RR_PIPE_LOCK_EN
    // ch1 holds the grant for a 3-beat packet while ch0 and ch2 wait.
    task automatic test_lock();
        do_reset();
        // One single-beat transfer from ch0 moves ptr to 1.
        in_valid4  = 4'b0001;
        in_data4   = {8'h00, 8'hD2, 8'h00, 8'hB0};
        in_last4   = 4'hF;
        out_ready4 = 1'b1;
        tick();
        total++; if (out_sel4 !== 2'd0 || out_last4 !== 1'b1) begin bad++; $display("FAIL lock_setup: got s=%0d l=%b want s=0 l=1", out_sel4, out_last4); end
        in_valid4 = 4'b0111;
        in_data4  = {8'h00, 8'hD2, 8'hC1, 8'hB0};
        in_last4  = 4'b1101;
        #1;
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL lock_ready_pre: got %b want 0010", in_ready4); end
        tick();
        total++; if (out_sel4 !== 2'd1 || out_data4 !== 8'hC1 || out_last4 !== 1'b0) begin bad++; $display("FAIL lock_beat1: got s=%0d d=%h l=%b want s=1 d=c1 l=0", out_sel4, out_data4, out_last4); end
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL lock_ready_held: got %b want 0010", in_ready4); end
        in_data4[15:8] = 8'hC2;
        tick();
        total++; if (out_sel4 !== 2'd1 || out_data4 !== 8'hC2 || out_last4 !== 1'b0) begin bad++; $display("FAIL lock_beat2: got s=%0d d=%h l=%b want s=1 d=c2 l=0", out_sel4, out_data4, out_last4); end
        in_data4[15:8] = 8'hC3;
        in_last4       = 4'hF;
        tick();
        total++; if (out_sel4 !== 2'd1 || out_data4 !== 8'hC3 || out_last4 !== 1'b1) begin bad++; $display("FAIL lock_beat3: got s=%0d d=%h l=%b want s=1 d=c3 l=1", out_sel4, out_data4, out_last4); end
        in_valid4 = 4'b0101;
        #1;
        total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL lock_release_ready: got %b want 0100", in_ready4); end
        tick();
        total++; if (out_sel4 !== 2'd2 || out_data4 !== 8'hD2 || out_last4 !== 1'b1) begin bad++; $display("FAIL lock_after2: got s=%0d d=%h l=%b want s=2 d=d2 l=1", out_sel4, out_data4, out_last4); end
        tick();
        total++; if (out_sel4 !== 2'd0 || out_data4 !== 8'hB0 || out_last4 !== 1'b1) begin bad++; $display("FAIL lock_after0: got s=%0d d=%h l=%b want s=0 d=b0 l=1", out_sel4, out_data4, out_last4); end
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_async_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_n3();
`ifdef MUXNM_RR_PIPE_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
